// File: rtl/amp_fault_ctrl.sv
// Amplifier power-sequencing and fault-recovery controller: power-up hold-off,
// filtered fault detection, timed retry and lockout after repeated faults.
module amp_fault_ctrl #(
    parameter int PWRUP_CYC  = 250000,
    parameter int RETRY_CYC  = 250000,
    parameter int FLT_FILT   = 16,
    parameter int UNMUTE_CYC = 4096,
    parameter int STABLE_CYC = 2500000,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Flt_n,
    input  logic       clr_lock,
    output logic       sht_dwn,
    output logic       mute,
    output logic       locked,
    output logic [2:0] state,
    output logic [7:0] fault_cnt
);

    typedef enum logic [2:0] {
        PWRUP = 3'd0,
        RUN   = 3'd1,
        FAULT = 3'd2,
        LOCK  = 3'd3
    } state_t;

    localparam int CYC_MAX = (PWRUP_CYC > RETRY_CYC)
                           ? ((PWRUP_CYC > UNMUTE_CYC) ? PWRUP_CYC : UNMUTE_CYC)
                           : ((RETRY_CYC > UNMUTE_CYC) ? RETRY_CYC : UNMUTE_CYC);
    localparam int CW = $clog2(CYC_MAX + 1);
    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int FW = $clog2(FLT_FILT + 1);

    localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0] RETRY_LAST = CW'(RETRY_CYC - 1);
    localparam logic [CW-1:0] UNMUTE_END = CW'(UNMUTE_CYC);
    localparam logic [SW-1:0] STABLE_END = SW'(STABLE_CYC);
    localparam logic [FW-1:0] FILT_LAST  = FW'(FLT_FILT - 1);
    localparam logic [7:0]    RETRY_MAX  = 8'(MAX_RETRY);

    state_t        cur_state;
    state_t        next_state;
    logic          sync1;
    logic          s;
    logic [CW-1:0] cyc_cnt;
    logic [CW-1:0] cyc_next;
    logic [SW-1:0] stable_cnt;
    logic [SW-1:0] stable_next;
    logic [FW-1:0] filt_cnt;
    logic [FW-1:0] filt_next;
    logic [7:0]    retry_cnt;
    logic [7:0]    retry_next;
    logic [7:0]    fault_next;

    assign state = cur_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
        end else begin
            sync1 <= Flt_n;
            s     <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state  <= PWRUP;
            cyc_cnt    <= '0;
            stable_cnt <= '0;
            filt_cnt   <= '0;
            retry_cnt  <= '0;
            fault_cnt  <= '0;
            sht_dwn    <= 1'b1;
            mute       <= 1'b1;
            locked     <= 1'b0;
        end else begin
            cur_state  <= next_state;
            cyc_cnt    <= cyc_next;
            stable_cnt <= stable_next;
            filt_cnt   <= filt_next;
            retry_cnt  <= retry_next;
            fault_cnt  <= fault_next;
            sht_dwn    <= (next_state != RUN);
            mute       <= (next_state != RUN) || (cyc_next < UNMUTE_END);
            locked     <= (next_state == LOCK);
        end
    end

    // Outputs are registered from the next-state values so they change on the
    // same edge as the state transition that causes them.
    always_comb begin
        next_state  = cur_state;
        cyc_next    = cyc_cnt;
        stable_next = '0;
        filt_next   = '0;
        retry_next  = retry_cnt;
        fault_next  = fault_cnt;

        case (cur_state)
            PWRUP: begin
                if (cyc_cnt == PWRUP_LAST) begin
                    next_state = RUN;
                    cyc_next   = '0;
                end else begin
                    cyc_next = cyc_cnt + 1'b1;
                end
            end

            RUN: begin
                cyc_next    = (cyc_cnt >= UNMUTE_END) ? cyc_cnt : cyc_cnt + 1'b1;
                stable_next = (stable_cnt >= STABLE_END) ? stable_cnt : stable_cnt + 1'b1;
                if (stable_next == STABLE_END) begin
                    retry_next = '0;
                end
                filt_next = s ? '0 : filt_cnt + 1'b1;
                // retry_next already reflects a stable-period clear on this same edge
                if (!s && (filt_cnt == FILT_LAST)) begin
                    retry_next  = retry_next + 8'd1;
                    fault_next  = (fault_cnt == 8'hFF) ? fault_cnt : fault_cnt + 8'd1;
                    next_state  = (retry_next >= RETRY_MAX) ? LOCK : FAULT;
                    cyc_next    = '0;
                    stable_next = '0;
                    filt_next   = '0;
                end
            end

            FAULT: begin
                if (cyc_cnt == RETRY_LAST) begin
                    next_state = RUN;
                    cyc_next   = '0;
                end else begin
                    cyc_next = cyc_cnt + 1'b1;
                end
            end

            LOCK: begin
                cyc_next = '0;
                if (clr_lock) begin
                    next_state = PWRUP;
                    retry_next = '0;
                end
            end

            default: begin
                next_state = PWRUP;
                cyc_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_amp_fault_ctrl.sv
// Directed testbench for amp_fault_ctrl using the short test-plan timing
// parameters; outputs are checked 1 ns after each rising edge.
module tb_amp_fault_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       Flt_n;
    logic       clr_lock;
    logic       sht_dwn;
    logic       mute;
    logic       locked;
    logic [2:0] state;
    logic [7:0] fault_cnt;

    int testCount = 0;
    int failCount = 0;

    amp_fault_ctrl #(
        .PWRUP_CYC (20),
        .RETRY_CYC (10),
        .FLT_FILT  (4),
        .UNMUTE_CYC(5),
        .STABLE_CYC(50),
        .MAX_RETRY (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Flt_n    (Flt_n),
        .clr_lock (clr_lock),
        .sht_dwn  (sht_dwn),
        .mute     (mute),
        .locked   (locked),
        .state    (state),
        .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstIn, input logic fltIn, input logic clrIn);
        rst      = rstIn;
        Flt_n    = fltIn;
        clr_lock = clrIn;
    endtask

    // Advance n rising edges, then settle 1 ns so outputs can be sampled.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold Flt_n low from the next edge k; detection lands on edge k+5.
    task automatic causeFault(input string tag, input logic [2:0] expState,
                              input logic [7:0] expCnt);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(5);
        checkOutput({tag, " sht_dwn before detect"}, sht_dwn, 0);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput({tag, " state"}, state, expState);
        checkOutput({tag, " sht_dwn"}, sht_dwn, 1);
        checkOutput({tag, " mute"}, mute, 1);
        checkOutput({tag, " fault_cnt"}, fault_cnt, expCnt);
    endtask

    task automatic checkPowerUp(input string tag);
        tick(19);
        checkOutput({tag, " sht_dwn edge19"}, sht_dwn, 1);
        checkOutput({tag, " state edge19"}, state, 0);
        tick(1);
        checkOutput({tag, " sht_dwn edge20"}, sht_dwn, 0);
        checkOutput({tag, " state edge20"}, state, 1);
        checkOutput({tag, " mute edge20"}, mute, 1);
        tick(4);
        checkOutput({tag, " mute edge24"}, mute, 1);
        tick(1);
        checkOutput({tag, " mute edge25"}, mute, 0);
    endtask

    initial begin
        // Reset and power-up
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(2);
        checkOutput("reset sht_dwn", sht_dwn, 1);
        checkOutput("reset mute", mute, 1);
        checkOutput("reset locked", locked, 0);
        checkOutput("reset state", state, 0);
        checkOutput("reset fault_cnt", fault_cnt, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkPowerUp("pwrup");

        // Three-cycle glitch stays below the filter threshold
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick(6);
        checkOutput("glitch sht_dwn", sht_dwn, 0);
        checkOutput("glitch mute", mute, 0);
        checkOutput("glitch fault_cnt", fault_cnt, 0);
        checkOutput("glitch state", state, 1);

        // clr_lock outside LOCK does nothing
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("clr in run state", state, 1);
        checkOutput("clr in run sht_dwn", sht_dwn, 0);

        // Single fault and timed restart
        causeFault("fault1", 3'd2, 8'd1);
        tick(9);
        checkOutput("retry sht_dwn edge9", sht_dwn, 1);
        checkOutput("retry state edge9", state, 2);
        tick(1);
        checkOutput("retry sht_dwn edge10", sht_dwn, 0);
        checkOutput("retry state edge10", state, 1);
        checkOutput("retry mute edge10", mute, 1);
        tick(5);
        checkOutput("retry mute edge15", mute, 0);

        // Two more faults without a stable period lock the amps out
        causeFault("fault2", 3'd2, 8'd2);
        tick(10);
        checkOutput("fault2 back to run", state, 1);
        causeFault("fault3", 3'd3, 8'd3);
        checkOutput("lock locked", locked, 1);
        tick(30);
        checkOutput("lock held state", state, 3);
        checkOutput("lock held sht_dwn", sht_dwn, 1);
        checkOutput("lock held locked", locked, 1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("clr state", state, 0);
        checkOutput("clr locked", locked, 0);
        checkOutput("clr sht_dwn", sht_dwn, 1);
        checkOutput("clr fault_cnt kept", fault_cnt, 3);
        checkPowerUp("clr pwrup");

        // Reset asserted while in FAULT
        causeFault("prereset", 3'd2, 8'd4);
        tick(3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("midrst sht_dwn", sht_dwn, 1);
        checkOutput("midrst mute", mute, 1);
        checkOutput("midrst locked", locked, 0);
        checkOutput("midrst state", state, 0);
        checkOutput("midrst fault_cnt", fault_cnt, 0);
        checkPowerUp("midrst pwrup");

        // A stable run of 50+ cycles clears the retry count
        causeFault("rc1", 3'd2, 8'd1);
        tick(10);
        causeFault("rc2", 3'd2, 8'd2);
        tick(10);
        checkOutput("rc back to run", state, 1);
        tick(60);
        causeFault("rc3", 3'd2, 8'd3);
        tick(10);
        causeFault("rc4", 3'd2, 8'd4);
        checkOutput("rc4 locked", locked, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
